// File: rtl/capture_frame_controller_if.sv
// Sample-stream, RAM-port and readout-stream signals of the frame capture controller.
// The controller connects as master and the surrounding fabric as slave.
interface capture_frame_controller_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 13
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  in_valid, in_data, mem_rdata, out_ready,
        output mem_we, mem_addr, mem_wdata, out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, mem_rdata, out_ready,
        input  mem_we, mem_addr, mem_wdata, out_valid, out_data, out_last
    );
endinterface

// File: rtl/capture_frame_controller.sv
// Captures one frame of ADC samples (optionally level-triggered) into a single-port RAM,
// then streams it back out with backpressure; the shared RAM port is split by state.
module capture_frame_controller #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  read_start,
    input  logic                  abort,
    input  logic                  trig_en,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH-1:0] frame_len,
    capture_frame_controller_if.master bus,
    output logic                  busy,
    output logic                  frame_ready
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_READY, S_RD_ADDR, S_RD_WAIT, S_RD_OUT
    } state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_wrPtr, r_rdPtr, r_len;
    logic [DATA_WIDTH-1:0] r_trigLevel, r_prev;
    logic                  r_histValid;
    logic                  r_memWe;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic                  r_outValid, r_outLast;
    logic [DATA_WIDTH-1:0] r_outData;

    logic          w_startOk, w_trigger, w_capAccept, w_writeNow, w_lastWrite;
    logic          w_rdLast, w_rdAccept, w_readGo;
    logic [CW-1:0] w_lenFull;

    // A zero length encodes a full-depth frame, hence the extra counter bit.
    assign w_lenFull   = (frame_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, frame_len};
    assign w_startOk   = start && (r_state == S_IDLE || r_state == S_READY);
    assign w_trigger   = (r_state == S_ARMED) && bus.in_valid && r_histValid &&
                         (r_prev < r_trigLevel) && (bus.in_data >= r_trigLevel);
    assign w_capAccept = (r_state == S_CAPTURE) && bus.in_valid;
    assign w_writeNow  = w_trigger || w_capAccept;
    assign w_lastWrite = (r_wrPtr == r_len - 1'b1);
    assign w_rdLast    = (r_rdPtr == r_len - 1'b1);
    assign w_rdAccept  = (r_state == S_RD_OUT) && bus.out_ready;
    assign w_readGo    = (r_state == S_READY) && read_start && !start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start) w_next = trig_en ? S_ARMED : S_CAPTURE;
                S_ARMED:   if (w_trigger) w_next = w_lastWrite ? S_READY : S_CAPTURE;
                S_CAPTURE: if (w_capAccept && w_lastWrite) w_next = S_READY;
                S_READY: begin
                    if (start)           w_next = trig_en ? S_ARMED : S_CAPTURE;
                    else if (read_start) w_next = S_RD_ADDR;
                end
                S_RD_ADDR: w_next = S_RD_WAIT;
                S_RD_WAIT: w_next = S_RD_OUT;
                S_RD_OUT:  if (bus.out_ready) w_next = r_outLast ? S_IDLE : S_RD_ADDR;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Abort leaves r_memWe at its cleared default, which cancels any pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_len       <= '0;
            r_trigLevel <= '0;
            r_prev      <= '0;
            r_histValid <= 1'b0;
            r_memWe     <= 1'b0;
            r_wrAddr    <= '0;
            r_memWdata  <= '0;
            r_outValid  <= 1'b0;
            r_outLast   <= 1'b0;
            r_outData   <= '0;
        end else begin
            r_memWe <= 1'b0;
            if (abort) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end else begin
                if (w_startOk) begin
                    r_len       <= w_lenFull;
                    r_trigLevel <= trig_level;
                    r_histValid <= 1'b0;
                    r_wrPtr     <= '0;
                end
                if (r_state == S_ARMED && bus.in_valid) begin
                    r_prev      <= bus.in_data;
                    r_histValid <= 1'b1;
                end
                if (w_writeNow) begin
                    r_memWe    <= 1'b1;
                    r_wrAddr   <= r_wrPtr[ADDR_WIDTH-1:0];
                    r_memWdata <= bus.in_data;
                    r_wrPtr    <= r_wrPtr + 1'b1;
                end
                if (w_readGo) r_rdPtr <= '0;
                if (r_state == S_RD_WAIT) begin
                    r_outData  <= bus.mem_rdata;
                    r_outValid <= 1'b1;
                    r_outLast  <= w_rdLast;
                end
                if (w_rdAccept) begin
                    r_outValid <= 1'b0;
                    r_outLast  <= 1'b0;
                    r_rdPtr    <= r_rdPtr + 1'b1;
                end
            end
        end
    end

    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = (r_state == S_RD_ADDR) ? r_rdPtr[ADDR_WIDTH-1:0] : r_wrAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_last  = r_outLast;
    assign busy          = (r_state == S_ARMED) || (r_state == S_CAPTURE) ||
                           (r_state == S_RD_ADDR) || (r_state == S_RD_WAIT) ||
                           (r_state == S_RD_OUT);
    assign frame_ready   = (r_state == S_READY);
endmodule

// File: tb/tb_capture_frame_controller.sv
// Scoreboard bench for capture_frame_controller: stimulus pushes expected RAM writes and
// readout beats into queues, a negedge monitor pops and compares them as the DUT emits them.
module tb_capture_frame_controller;
    localparam int DW = 12;
    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, read_start = 1'b0, abort = 1'b0, trig_en = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] frame_len = '0;
    logic          busy, frame_ready;
    logic [DW-1:0] ram [16];

    wr_t wq[$];
    rd_t rq[$];
    int  total = 0;
    int  bad = 0;

    capture_frame_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    capture_frame_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .read_start  (read_start),
        .abort       (abort),
        .trig_en     (trig_en),
        .trig_level  (trig_level),
        .frame_len   (frame_len),
        .bus         (bus),
        .busy        (busy),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every write and every accepted readout beat must match the head of its queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    checkOutput("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    checkOutput("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                    checkOutput("wr_data", 32'(bus.mem_wdata), 32'(w.data));
                    checkOutput("wr_frame_ready", 32'(frame_ready), 32'(w.last));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rq.size() == 0) begin
                    checkOutput("unexpected_read", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    rd_t r;
                    r = rq.pop_front();
                    checkOutput("rd_data", 32'(bus.out_data), 32'(r.data));
                    checkOutput("rd_last", 32'(bus.out_last), 32'(r.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        tick();
    endtask

    task automatic armFrame(input logic te, input logic [DW-1:0] lvl, input logic [AW-1:0] len);
        trig_en    = te;
        trig_level = lvl;
        frame_len  = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic pushWrite(input int a, input int d, input logic l);
        wr_t w;
        w.addr = a[AW-1:0];
        w.data = d[DW-1:0];
        w.last = l;
        wq.push_back(w);
    endtask

    task automatic pushRead(input int d, input logic l);
        rd_t r;
        r.data = d[DW-1:0];
        r.last = l;
        rq.push_back(r);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_ready", 32'(frame_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        reset_n = 1'b1;
        tick();

        // Untriggered capture of 4 samples; the fifth must be ignored.
        armFrame(1'b0, '0, 4'd4);
        checkOutput("cap_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) pushWrite(i, 10 + i, i == 3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(10 + i));
        applyStimulus(1'b0, '0);
        repeat (2) tick();
        checkOutput("cap_frame_ready", 32'(frame_ready), 32'd1);
        checkOutput("cap_wq_empty", 32'(wq.size()), 32'd0);

        // Readout with a 5-cycle stall on sample 1.
        for (int i = 0; i < 4; i++) pushRead(10 + i, i == 3);
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitValid();
            if (k == 1) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("stall_data", 32'(bus.out_data), 32'd11);
                    checkOutput("stall_last", 32'(bus.out_last), 32'd0);
                end
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        checkOutput("rd_idle_busy", 32'(busy), 32'd0);
        checkOutput("rd_idle_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rd_rq_empty", 32'(rq.size()), 32'd0);

        // Level trigger: 50, 99 do not fire; 100 fires and becomes sample 0.
        armFrame(1'b1, 12'd100, 4'd2);
        pushWrite(0, 100, 1'b0);
        pushWrite(1, 120, 1'b1);
        applyStimulus(1'b1, 12'd50);
        applyStimulus(1'b1, 12'd99);
        applyStimulus(1'b1, 12'd100);
        applyStimulus(1'b1, 12'd120);
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("trig_frame_ready", 32'(frame_ready), 32'd1);
        checkOutput("trig_wq_empty", 32'(wq.size()), 32'd0);

        // First sample after arming cannot trigger even if above the level.
        armFrame(1'b1, 12'd100, 4'd2);
        applyStimulus(1'b1, 12'd200);
        applyStimulus(1'b0, '0);
        repeat (2) tick();
        checkOutput("notrig_busy", 32'(busy), 32'd1);
        checkOutput("notrig_frame_ready", 32'(frame_ready), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_armed_busy", 32'(busy), 32'd0);

        // Zero length means a full 16-sample frame.
        armFrame(1'b0, '0, 4'd0);
        for (int i = 0; i < 16; i++) pushWrite(i, 300 + i, i == 15);
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, DW'(300 + i));
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("full_frame_ready", 32'(frame_ready), 32'd1);
        checkOutput("full_wq_empty", 32'(wq.size()), 32'd0);

        // Abort together with an in_valid: that sample is never written.
        armFrame(1'b0, '0, 4'd4);
        pushWrite(0, 77, 1'b0);
        applyStimulus(1'b1, 12'd77);
        abort = 1'b1;
        applyStimulus(1'b1, 12'd78);
        abort = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("abort_frame_ready", 32'(frame_ready), 32'd0);

        // Abort beats start from IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("abort_wq_empty", 32'(wq.size()), 32'd0);

        // Asynchronous reset during readout.
        armFrame(1'b0, '0, 4'd2);
        pushWrite(0, 5, 1'b0);
        pushWrite(1, 6, 1'b1);
        applyStimulus(1'b1, 12'd5);
        applyStimulus(1'b1, 12'd6);
        applyStimulus(1'b0, '0);
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        waitValid();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_frame_ready", 32'(frame_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("final_wq_empty", 32'(wq.size()), 32'd0);
        checkOutput("final_rq_empty", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/capture_frame_controller.md
Name: capture_frame_controller

Overview:
Sequences one frame of ADC samples into a single-port sample RAM, then streams it out for the FFT loader. Handles arm, optional level trigger, frame-length counting and readback with backpressure. Shares the RAM's one address port between capture writes and readout reads by state, so the two never collide. Sits between the ADC sample stream and the FFT input buffer.

Parameters:
DATA_WIDTH, 12, sample width (unsigned)
ADDR_WIDTH, 13, RAM address width; maximum frame is 2^ADDR_WIDTH samples

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: arm capture and latch frame_len
read_start  in  1  pulse: begin readout of the captured frame
abort  in  1  pulse: return to IDLE from any state
trig_en  in  1  sampled at start; 1 = wait for trigger, 0 = capture immediately
trig_level  in  DATA_WIDTH  trigger threshold, sampled at start
frame_len  in  ADDR_WIDTH  samples per frame, sampled at start; 0 means 2^ADDR_WIDTH
in_valid  in  1  input sample strobe
in_data  in  DATA_WIDTH  input sample
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address, shared by reads and writes
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after the address
out_valid  out  1  readout sample valid
out_data  out  DATA_WIDTH  readout sample
out_last  out  1  marks the final sample of the frame
out_ready  in  1  downstream accept
busy  out  1  high in ARMED, CAPTURE and any READ state
frame_ready  out  1  high in READY

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0; wr_ptr, rd_ptr, latched length and trigger history cleared.
- States: IDLE, ARMED, CAPTURE, READY, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE or READY with start=1:
  - Latch frame_len and trig_level; clear the trigger-history-valid flag.
  - Go to ARMED if trig_en=1, else CAPTURE.
  - wr_ptr is set to 0.
- start in any other state is ignored.
- ARMED, each in_valid:
  - Record the sample as prev and set the history-valid flag.
  - Trigger when the history flag is set, prev < trig_level and in_data >= trig_level.
  - The triggering sample is written as sample 0, and the state moves to CAPTURE in the same cycle.
  - The first sample after arming can never trigger.
- CAPTURE, each in_valid:
  - Next cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=in_data.
  - wr_ptr increments on the accepted sample, so write latency is 1 cycle.
  - Back-to-back in_valid writes every cycle.
- Completion: when the accepted sample is number len-1, go to READY.
  - Its write still issues on the next cycle.
  - frame_ready asserts on that same cycle.
- in_valid in IDLE, READY and the RD_* states is ignored; there is no write.
- READY with read_start=1: rd_ptr=0, go to RD_ADDR. read_start in other states is ignored.
- start and read_start together in READY: start wins.
- Readout sequence:
  - RD_ADDR drives mem_addr=rd_ptr with mem_we=0, then goes to RD_WAIT.
  - RD_WAIT registers mem_rdata into out_data, sets out_valid=1, then goes to RD_OUT.
  - RD_OUT holds out_valid, out_data and out_last stable until out_ready=1.
  - On accept: out_valid drops next cycle and rd_ptr increments.
  - If it was the last sample (rd_ptr==len-1, out_last=1), go to IDLE; otherwise go to RD_ADDR.
  - Maximum throughput is 1 sample per 3 cycles; only one read is ever outstanding.
- Port sharing: mem_we=1 only for the single cycle after a CAPTURE accept. Reads occur only in RD_ADDR. The two never overlap by construction.
- Length 0: treated as 2^ADDR_WIDTH. Counters are ADDR_WIDTH+1 bits so a full-depth frame completes without wrap ambiguity.
- abort:
  - From any state, next cycle state=IDLE, out_valid=0, out_last=0, frame_ready=0.
  - A write already scheduled for that next cycle is suppressed (mem_we=0).
  - abort has priority over start, read_start and in_valid in the same cycle.
- Reset asserted mid-capture or mid-readout behaves exactly as abort, asynchronously. RAM contents are not cleared.

Test Plan:
- trig_en=0, frame_len=4, in_valid every cycle with data 10,11,12,13: mem_we high 4 consecutive cycles at addr 0..3 with 10..13; frame_ready rises on the cycle of the addr-3 write; a 5th sample is ignored.
- trig_en=1, level=100, stream 50,99,100,120 with frame_len=2: first write is addr 0=100, then addr 1=120. Separately, arming followed by a first sample of 200 must not trigger.
- Readout of frame 10..13 with out_ready held low for 5 cycles on sample 1: out_data stays 11 and stable; out_last=1 only on 13; IDLE after accept.
- frame_len=0 with ADDR_WIDTH=4: exactly 16 writes, addr 0..15, then READY.
- abort on the cycle after a CAPTURE accept: no mem_we next cycle, state IDLE; abort and start in the same cycle from IDLE leaves it in IDLE.
- reset_n pulsed low mid-readout without a clock edge: out_valid=0 and busy=0 immediately.
